column_input_ctrl: RTL
======================

COLUMN_INPUT_CTRL -- requirements
Module: column_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized cycles required before a press or release is accepted (legal 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port btn, input, 4, raw asynchronous column buttons, active-high, bit i = column i.
REQ-005 SHALL have port game_status, input, 2, game state from board FSM; 00 = in play, any other value = game over.
REQ-006 SHALL have port ready, input, 1, board FSM can accept a move when 1.
REQ-007 SHALL have port in_column, output, 4, active-low one-hot column code to board FSM (1110 = col 0 ... 0111 = col 3, 1111 = none).
REQ-008 SHALL have port enable, output, 1, single-cycle move strobe qualifying in_column.
REQ-009 SHALL have port multi_err, output, 1, single-cycle pulse on a multi-button press.
REQ-010 SHALL have port current_state, output, 2, FSM state code.
REQ-011 SHALL have port move_count, output, 8, number of moves issued since reset.

Function
REQ-012 SHALL pass btn through a 2-flop synchronizer; all decisions use synchronized value sbtn only.
REQ-013 SHALL implement states IDLE=00, DEBOUNCE=01, ISSUE=10, WAIT_RELEASE=11 on current_state.
REQ-014 IDLE: sbtn one-hot and game_status==00 -> capture sbtn, load debounce counter, go DEBOUNCE.
REQ-015 IDLE: sbtn with 2+ bits set -> multi_err high 1 cycle, go WAIT_RELEASE, no enable.
REQ-016 IDLE: sbtn==0000 or game_status!=00 -> stay; presses during game over ignored.
REQ-017 DEBOUNCE: sbtn != captured value, or game_status != 00 -> return to IDLE, no output.
REQ-018 DEBOUNCE: after DEBOUNCE_CYCLES consecutive matching cycles and ready==1 -> ISSUE; ready==0 -> stay, keep checking stability, advance on first cycle ready==1.
REQ-019 ISSUE: lasts exactly 1 cycle; enable=1; in_column = ~captured; move_count += 1; next WAIT_RELEASE.
REQ-020 enable, in_column, multi_err, move_count SHALL be registered outputs.
REQ-021 in_column SHALL hold the issued code through WAIT_RELEASE and return to 1111 on entry to IDLE; 1111 in all other states.
REQ-022 WAIT_RELEASE: leave to IDLE only after sbtn==0000 for DEBOUNCE_CYCLES consecutive cycles; any nonzero sbtn restarts the count; no enable while held.
REQ-023 Latency: counting first clock edge sampling btn high as edge 1, stable btn, ready=1 -> enable high for cycle following edge DEBOUNCE_CYCLES+3 (edge 7 at default).
REQ-024 Exactly one enable per accepted press regardless of hold duration.
REQ-025 move_count SHALL wrap 255 -> 0 without flag.
REQ-026 Debounce counter width SHALL be 16 bits; no other arithmetic overflow permitted.

Reset
REQ-027 reset low SHALL immediately force: state IDLE, in_column=1111, enable=0, multi_err=0, move_count=0, synchronizer and debounce counter cleared.
REQ-028 Reset asserted mid-operation (any state) SHALL abort without emitting enable; after release a still-held button is treated as a new press.
REQ-029 Reset release SHALL take effect at next clk edge; no output pulses on release.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset low with btn=0001 -> in_column=1111, enable=0, current_state=00, move_count=0 throughout.
REQ-031 btn=0001 held 20 cycles, ready=1 -> one enable pulse at edge 7, in_column=1110, move_count=1; btn=0000 for 6 cycles -> state 00, in_column=1111.
REQ-032 btn=0010 2 cycles, 0000 1 cycle, then 0010 held -> no enable from first burst; one pulse, in_column=1101, 4+ stable cycles after re-press.
REQ-033 btn=0110 -> multi_err one cycle, no enable, state 11 until released 4 cycles.
REQ-034 game_status=01, btn=1000 held -> no enable, state stays 00; ready=0 then 1 after 10 cycles with btn=1000, game_status=00 -> enable cycle after ready seen, in_column=0111.
REQ-035 256 accepted presses -> move_count returns to 0.

Source files
------------

// File: rtl/column_input_ctrl.sv
// rtl/column_input_ctrl.sv - debounced column button decoder issuing single move strobes to the board FSM
module column_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [1:0] game_status,
    input  logic       ready,
    output logic [3:0] in_column,
    output logic       enable,
    output logic       multi_err,
    output logic [1:0] current_state,
    output logic [7:0] move_count
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        DEBOUNCE     = 2'b01,
        ISSUE        = 2'b10,
        WAIT_RELEASE = 2'b11
    } state_t;

    // Counter runs 0..LAST, so reaching LAST marks DEBOUNCE_CYCLES stable samples.
    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    logic [3:0]  sync1;
    logic [3:0]  sbtn;
    logic [3:0]  captured;
    logic [15:0] cnt;
    logic        game_on;
    logic        one_hot;
    logic        multi;

    assign game_on       = (game_status == 2'b00);
    assign one_hot       = (sbtn != 4'b0000) && ((sbtn & (sbtn - 4'd1)) == 4'b0000);
    assign multi         = (sbtn != 4'b0000) && !one_hot;
    assign current_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sync1      <= 4'b0000;
            sbtn       <= 4'b0000;
            captured   <= 4'b0000;
            cnt        <= 16'd0;
            in_column  <= 4'b1111;
            enable     <= 1'b0;
            multi_err  <= 1'b0;
            move_count <= 8'd0;
        end else begin
            sync1     <= btn;
            sbtn      <= sync1;
            enable    <= 1'b0;
            multi_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (game_on) begin
                        if (one_hot) begin
                            captured <= sbtn;
                            cnt      <= 16'd0;
                            state    <= DEBOUNCE;
                        end else if (multi) begin
                            multi_err <= 1'b1;
                            cnt       <= 16'd0;
                            state     <= WAIT_RELEASE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sbtn != captured || !game_on) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        // Counter saturates here while the board is busy.
                        if (ready) begin
                            state      <= ISSUE;
                            enable     <= 1'b1;
                            in_column  <= ~captured;
                            move_count <= move_count + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ISSUE: begin
                    cnt   <= 16'd0;
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (sbtn != 4'b0000) begin
                        cnt <= 16'd0;
                    end else if (cnt == LAST) begin
                        state     <= IDLE;
                        in_column <= 4'b1111;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
